// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM multi-channel arbiter: FSM states, channel slot payload,
// and data-path widths.
package sdram_arb_pkg;

    localparam int unsigned SLOT_AW = 26;
    localparam int unsigned DW      = 16;
    localparam int unsigned RDW     = 64;
    localparam int unsigned BSW     = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic               we;
        logic               burst;
        logic [SLOT_AW-1:0] addr;
        logic [DW-1:0]      wdata;
        logic [BSW-1:0]     bs;
    } slot_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational grant selector: starved pending channels win first, lowest index
// breaks ties; otherwise the lowest-index pending channel wins.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned IW  = idx_w(NCH)
) (
    input  logic [NCH-1:0] pend,
    input  logic [NCH-1:0] starved,
    output logic [NCH-1:0] grant_c,
    output logic [IW-1:0]  idx_c,
    output logic           any_c
);

    logic [NCH-1:0] cand_c;

    // Walk downward so the lowest candidate index is the last one written.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = |pend;
        cand_c  = (|(pend & starved)) ? (pend & starved) : pend;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (cand_c[i]) begin
                grant_c    = '0;
                grant_c[i] = 1'b1;
                idx_c      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sdram_arb.sv
// Multi-channel SDRAM arbiter: posts one access per request rising edge, grants with
// fixed priority plus starvation promotion, and sequences a single-command handshake.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned AW         = SLOT_AW,
    parameter int unsigned STARVE_MAX = 7
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic [NCH-1:0]     CH_REQ,
    input  logic [NCH-1:0]     CH_WE,
    input  logic [NCH-1:0]     CH_BURST,
    input  logic [NCH*AW-1:0]  CH_ADDR,
    input  logic [NCH*DW-1:0]  CH_WDATA,
    input  logic [NCH*BSW-1:0] CH_BS,
    output logic [NCH*RDW-1:0] CH_RDATA,
    output logic [NCH-1:0]     CH_DONE,
    output logic [NCH-1:0]     CH_OVF,
    output logic               SDRAM_RD,
    output logic               SDRAM_WR,
    output logic               SDRAM_BURST,
    output logic [AW-1:0]      SDRAM_ADDR,
    output logic [DW-1:0]      SDRAM_DIN,
    output logic [BSW-1:0]     SDRAM_BS,
    input  logic [RDW-1:0]     SDRAM_DOUT,
    input  logic               SDRAM_READY,
    output logic               BUSY
);

    localparam int unsigned IW   = idx_w(NCH);
    localparam int unsigned SMAX = (STARVE_MAX > 0) ? STARVE_MAX : 1;
    localparam int unsigned SW   = $clog2(SMAX + 1);

    state_t         state, state_next;
    logic [NCH-1:0] req_q, pend;
    logic           ready_q;
    slot_t          slot [NCH];
    logic [SW-1:0]  starve [NCH];
    logic [IW-1:0]  act_idx;
    logic           act_we, act_burst;

    logic [NCH-1:0] rise_c, post_c, pend_eff_c, starved_c, grant_c;
    logic [NCH-1:0] done_mask_c, clr_mask_c;
    slot_t          slot_eff_c [NCH];
    slot_t          sel_c;
    logic [IW-1:0]  pick_idx_c;
    logic           pick_any_c;
    logic           grant_fire_c, capture_c;

    // Edge posting; an edge for the channel finishing this cycle is accepted since its PEND clears now.
    always_comb begin
        rise_c = CH_REQ & ~req_q;
        for (int i = 0; i < int'(NCH); i++) begin
            post_c[i]     = rise_c[i] && (!pend[i] || (state == ST_DONE && act_idx == IW'(i)));
            slot_eff_c[i] = slot[i];
            if (post_c[i]) begin
                slot_eff_c[i] = '{we:    CH_WE[i],
                                  burst: CH_BURST[i],
                                  addr:  SLOT_AW'(CH_ADDR[i*AW +: AW]),
                                  wdata: CH_WDATA[i*DW +: DW],
                                  bs:    CH_BS[i*BSW +: BSW]};
            end
            starved_c[i] = (starve[i] >= SW'(SMAX));
        end
        pend_eff_c = pend | post_c;
    end

    sdram_arb_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .pend    (pend_eff_c),
        .starved (starved_c),
        .grant_c (grant_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (SDRAM_READY && pick_any_c)  state_next = ST_ISSUE;
            ST_ISSUE: if (ready_q && !SDRAM_READY)    state_next = ST_WAIT;
            ST_WAIT:  if (SDRAM_READY)                state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_fire_c = (state == ST_IDLE) && (state_next == ST_ISSUE);
        capture_c    = (state == ST_WAIT) && (state_next == ST_DONE);
        sel_c        = slot_eff_c[0];
        for (int i = 0; i < int'(NCH); i++) begin
            if (grant_c[i]) sel_c = slot_eff_c[i];
            done_mask_c[i] = (act_idx == IW'(i));
        end
        clr_mask_c = (state == ST_DONE) ? done_mask_c : '0;
    end

    // Per-channel request bookkeeping and starvation counters.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            req_q   <= '0;
            ready_q <= 1'b0;
            pend    <= '0;
            CH_OVF  <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                slot[i]   <= '0;
                starve[i] <= '0;
            end
        end else begin
            req_q   <= CH_REQ;
            ready_q <= SDRAM_READY;
            pend    <= (pend & ~clr_mask_c) | post_c;
            CH_OVF  <= CH_OVF | (rise_c & ~post_c);
            for (int i = 0; i < int'(NCH); i++) begin
                if (post_c[i]) slot[i] <= slot_eff_c[i];
                if (grant_fire_c) begin
                    if (grant_c[i])
                        starve[i] <= '0;
                    else if (pend_eff_c[i] && starve[i] != SW'(SMAX))
                        starve[i] <= starve[i] + 1'b1;
                end
            end
        end
    end

    // Command drive, completion pulse and read-data capture.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            act_idx     <= '0;
            act_we      <= 1'b0;
            act_burst   <= 1'b0;
            SDRAM_RD    <= 1'b0;
            SDRAM_WR    <= 1'b0;
            SDRAM_BURST <= 1'b0;
            SDRAM_ADDR  <= '0;
            SDRAM_DIN   <= '0;
            SDRAM_BS    <= 2'b11;
            CH_DONE     <= '0;
            CH_RDATA    <= '0;
            BUSY        <= 1'b0;
        end else begin
            if (grant_fire_c) begin
                act_idx     <= pick_idx_c;
                act_we      <= sel_c.we;
                act_burst   <= sel_c.burst && !sel_c.we;
                SDRAM_RD    <= !sel_c.we;
                SDRAM_WR    <= sel_c.we;
                SDRAM_BURST <= sel_c.burst && !sel_c.we;
                SDRAM_ADDR  <= AW'(sel_c.addr);
                SDRAM_DIN   <= sel_c.wdata;
                SDRAM_BS    <= sel_c.we ? sel_c.bs : 2'b11;
            end else if (state_next != ST_ISSUE) begin
                SDRAM_RD    <= 1'b0;
                SDRAM_WR    <= 1'b0;
                SDRAM_BURST <= 1'b0;
            end
            CH_DONE <= capture_c ? done_mask_c : '0;
            if (capture_c && !act_we) begin
                for (int i = 0; i < int'(NCH); i++) begin
                    if (done_mask_c[i])
                        CH_RDATA[i*RDW +: RDW] <= act_burst ? SDRAM_DOUT
                                                            : {48'h0, SDRAM_DOUT[15:0]};
                end
            end
            BUSY <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb: a behavioural SDRAM controller answers commands,
// expected commands/completions are queued at stimulus time and checked as they appear.
module tb_sdram_arb;

    localparam int NCH = 4;
    localparam int AW  = 26;

    logic               CLK = 1'b0;
    logic               nRESET;
    logic [NCH-1:0]     CH_REQ, CH_WE, CH_BURST;
    logic [NCH*AW-1:0]  CH_ADDR;
    logic [NCH*16-1:0]  CH_WDATA;
    logic [NCH*2-1:0]   CH_BS;
    logic [NCH*64-1:0]  CH_RDATA;
    logic [NCH-1:0]     CH_DONE, CH_OVF;
    logic               SDRAM_RD, SDRAM_WR, SDRAM_BURST;
    logic [AW-1:0]      SDRAM_ADDR;
    logic [15:0]        SDRAM_DIN;
    logic [1:0]         SDRAM_BS;
    logic [63:0]        SDRAM_DOUT;
    logic               SDRAM_READY;
    logic               BUSY;

    sdram_arb #(.NCH(NCH), .AW(AW), .STARVE_MAX(7)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .CH_REQ(CH_REQ), .CH_WE(CH_WE), .CH_BURST(CH_BURST), .CH_ADDR(CH_ADDR),
        .CH_WDATA(CH_WDATA), .CH_BS(CH_BS), .CH_RDATA(CH_RDATA), .CH_DONE(CH_DONE),
        .CH_OVF(CH_OVF), .SDRAM_RD(SDRAM_RD), .SDRAM_WR(SDRAM_WR),
        .SDRAM_BURST(SDRAM_BURST), .SDRAM_ADDR(SDRAM_ADDR), .SDRAM_DIN(SDRAM_DIN),
        .SDRAM_BS(SDRAM_BS), .SDRAM_DOUT(SDRAM_DOUT), .SDRAM_READY(SDRAM_READY),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          we;
        logic          burst;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    bs;
    } cmd_t;

    typedef struct {
        int          ch;
        logic [63:0] rdata;
    } done_t;

    cmd_t  cmd_q [$];
    done_t done_q[$];
    int    total = 0;
    int    bad   = 0;
    int    lat   = 1;
    bit    stall = 1'b0;

    logic [63:0]   last_rd [NCH];
    logic          st_we   [NCH];
    logic          st_burst[NCH];
    logic [AW-1:0] st_addr [NCH];
    logic [15:0]   st_wd   [NCH];
    logic [1:0]    st_bs   [NCH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_dout(input logic [AW-1:0] a);
        logic [15:0] l;
        l = a[15:0];
        return {l ^ 16'h5A5A, 16'hC0DE, ~l, l + 16'h1234};
    endfunction

    task automatic load(input int ch, input logic we, input logic burst,
                        input logic [AW-1:0] addr, input logic [15:0] wd, input logic [1:0] bs);
        st_we[ch] = we; st_burst[ch] = burst; st_addr[ch] = addr;
        st_wd[ch] = wd; st_bs[ch] = bs;
        CH_WE[ch] = we; CH_BURST[ch] = burst;
        CH_ADDR[ch*AW +: AW] = addr;
        CH_WDATA[ch*16 +: 16] = wd;
        CH_BS[ch*2 +: 2] = bs;
    endtask

    task automatic push_cmd(input int ch);
        cmd_t c;
        c.we    = st_we[ch];
        c.burst = st_burst[ch] && !st_we[ch];
        c.addr  = st_addr[ch];
        c.din   = st_wd[ch];
        c.bs    = st_we[ch] ? st_bs[ch] : 2'b11;
        cmd_q.push_back(c);
    endtask

    task automatic push_done(input int ch);
        done_t       d;
        logic [63:0] w;
        if (!st_we[ch]) begin
            w = model_dout(st_addr[ch]);
            if (!st_burst[ch]) w = {48'h0, w[15:0]};
            last_rd[ch] = w;
        end
        d.ch    = ch;
        d.rdata = last_rd[ch];
        done_q.push_back(d);
    endtask

    task automatic expect_tx(input int ch);
        push_cmd(ch);
        push_done(ch);
    endtask

    task automatic fire(input logic [NCH-1:0] m);
        @(negedge CLK);
        CH_REQ = CH_REQ | m;
        @(negedge CLK);
        CH_REQ = CH_REQ & ~m;
    endtask

    task automatic drain();
        int n = 0;
        while ((cmd_q.size() != 0 || done_q.size() != 0) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("drain", 64'(cmd_q.size() + done_q.size()), 64'd0);
        repeat (10) @(negedge CLK);
    endtask

    task automatic wait_done(input int ch);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!CH_DONE[ch] && n < 200);
        check("wait_done", 64'(CH_DONE[ch]), 64'd1);
    endtask

    // Behavioural controller: drops READY for lat cycles per accepted command.
    initial begin
        logic [AW-1:0] a;
        SDRAM_READY = 1'b1;
        SDRAM_DOUT  = '0;
        forever begin
            @(negedge CLK);
            if (nRESET && !stall && SDRAM_READY && (SDRAM_RD || SDRAM_WR)) begin
                a = SDRAM_ADDR;
                SDRAM_READY = 1'b0;
                repeat (lat) @(negedge CLK);
                SDRAM_DOUT  = model_dout(a);
                SDRAM_READY = 1'b1;
            end
        end
    end

    // Command monitor: checks the first cycle of each issued command.
    initial begin
        logic prev, now;
        cmd_t c;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            now = SDRAM_RD | SDRAM_WR;
            if (nRESET && now && !prev) begin
                if (cmd_q.size() == 0) begin
                    check("spurious_cmd", 64'(now), 64'd0);
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd_wr",    64'(SDRAM_WR),    64'(c.we));
                    check("cmd_rd",    64'(SDRAM_RD),    64'(!c.we));
                    check("cmd_addr",  64'(SDRAM_ADDR),  64'(c.addr));
                    check("cmd_bs",    64'(SDRAM_BS),    64'(c.bs));
                    check("cmd_burst", 64'(SDRAM_BURST), 64'(c.burst));
                    if (c.we) check("cmd_din", 64'(SDRAM_DIN), 64'(c.din));
                end
            end
            prev = now;
        end
    end

    // Completion monitor: order, channel and returned data.
    initial begin
        done_t e;
        forever begin
            @(negedge CLK);
            if (nRESET && CH_DONE != '0) begin
                if (done_q.size() == 0) begin
                    check("spurious_done", 64'(CH_DONE), 64'd0);
                end else begin
                    e = done_q.pop_front();
                    check("done_ch", 64'(CH_DONE), 64'd1 << e.ch);
                    check("rdata",   CH_RDATA[e.ch*64 +: 64], e.rdata);
                end
            end
        end
    end

    initial begin
        #300000;
        check("watchdog", 64'd0, 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        nRESET = 1'b0;
        CH_REQ = '0; CH_WE = '0; CH_BURST = '0;
        CH_ADDR = '0; CH_WDATA = '0; CH_BS = '0;
        for (int i = 0; i < NCH; i++) last_rd[i] = '0;
        repeat (3) @(negedge CLK);
        check("rst_busy",  64'(BUSY), 64'd0);
        check("rst_rdwr",  64'({SDRAM_RD, SDRAM_WR, SDRAM_BURST}), 64'd0);
        check("rst_done",  64'(CH_DONE), 64'd0);
        check("rst_ovf",   64'(CH_OVF), 64'd0);
        check("rst_rdata", 64'(|CH_RDATA), 64'd0);
        check("rst_addr",  64'(SDRAM_ADDR), 64'd0);
        check("rst_din",   64'(SDRAM_DIN), 64'd0);
        check("rst_bs",    64'(SDRAM_BS), 64'd3);
        nRESET = 1'b1;
        repeat (2) @(negedge CLK);

        // single read on ch2; CH_BS ignored for reads
        lat = 1;
        load(2, 1'b0, 1'b0, 26'h0100000, 16'hFFFF, 2'b00);
        expect_tx(2);
        fire(4'b0100);
        drain();
        check("rd2_lo", 64'(CH_RDATA[2*64 +: 16]), 64'h1234);

        // simultaneous ch0 + ch3: ch0 first
        load(0, 1'b0, 1'b0, 26'h0000ABC, 16'h0, 2'b01);
        load(3, 1'b0, 1'b0, 26'h3FFFF00, 16'h0, 2'b10);
        expect_tx(0);
        expect_tx(3);
        fire(4'b1001);
        drain();

        // four-way mixed traffic with burst read and burst-ignored write
        lat = 2;
        load(0, 1'b1, 1'b0, 26'h0001000, 16'h1111, 2'b10);
        load(1, 1'b0, 1'b1, 26'h0002468, 16'h0000, 2'b00);
        load(2, 1'b0, 1'b0, 26'h000ACE1, 16'h2222, 2'b01);
        load(3, 1'b1, 1'b1, 26'h2000777, 16'h3333, 2'b11);
        for (int i = 0; i < NCH; i++) expect_tx(i);
        fire(4'b1111);
        drain();
        check("ovf_mixed", 64'(CH_OVF), 64'd0);

        // starvation: ch0 keeps re-requesting, ch3 must win on the 8th grant
        lat = 1;
        load(0, 1'b0, 1'b0, 26'h0000010, 16'h0, 2'b00);
        load(3, 1'b0, 1'b0, 26'h0000030, 16'h0, 2'b00);
        for (int k = 0; k < 7; k++) expect_tx(0);
        expect_tx(3);
        expect_tx(0);
        fire(4'b1001);
        for (int k = 0; k < 7; k++) begin
            wait_done(0);
            CH_REQ[0] = 1'b1;
            @(negedge CLK);
            CH_REQ[0] = 1'b0;
        end
        drain();
        check("ovf_starve", 64'(CH_OVF), 64'd0);

        // ch1 write, then a second ch1 edge while the write is in WAIT
        lat = 3;
        load(1, 1'b1, 1'b0, 26'h0001234, 16'hBEEF, 2'b01);
        expect_tx(1);
        fire(4'b0010);
        begin
            int n = 0;
            while (SDRAM_WR && n < 50) begin
                @(negedge CLK);
                n++;
            end
        end
        check("in_wait", 64'({BUSY, SDRAM_WR, SDRAM_READY}), 64'b100);
        CH_REQ[1] = 1'b1;
        @(negedge CLK);
        check("ovf1", 64'(CH_OVF), 64'b0010);
        CH_REQ[1] = 1'b0;
        drain();
        check("ovf1_sticky", 64'(CH_OVF), 64'b0010);

        // reset while the read command is being issued
        stall = 1'b1;
        lat   = 1;
        load(2, 1'b0, 1'b0, 26'h0000777, 16'h0, 2'b00);
        push_cmd(2);
        fire(4'b0100);
        check("issue_rd", 64'(SDRAM_RD), 64'd1);
        nRESET = 1'b0;
        #1;
        check("rst_async_rd",   64'(SDRAM_RD), 64'd0);
        check("rst_async_busy", 64'(BUSY), 64'd0);
        repeat (2) @(negedge CLK);
        check("rst_ovf_clr",   64'(CH_OVF), 64'd0);
        check("rst_rdata_clr", 64'(|CH_RDATA), 64'd0);
        for (int i = 0; i < NCH; i++) last_rd[i] = '0;
        nRESET = 1'b1;
        stall  = 1'b0;
        repeat (12) @(negedge CLK);
        check("post_rst_idle", 64'({BUSY, SDRAM_RD, SDRAM_WR}), 64'd0);
        check("post_rst_q",    64'(cmd_q.size() + done_q.size()), 64'd0);

        // after reset, ch2 posts normally (no stale pending, no overflow)
        load(2, 1'b0, 1'b1, 26'h0004321, 16'h0, 2'b00);
        expect_tx(2);
        fire(4'b0100);
        drain();
        check("post_rst_ovf", 64'(CH_OVF), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
